cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Synthesizable run sequencer for one or more MIYAJIRO_CPU instances.
- Replaces fixed bench-level reset and timeout delays with a parametrised block that:
  - holds the cores in reset for a set number of cycles, then releases them;
  - counts run cycles and detects per-core halt;
  - ends the run as DONE or TIMEOUT.
- Sits between the top-level clock/reset and the cores' reset_n inputs; usable in simulation tops and FPGA wrappers.

Parameters:
- NUM_CORES, 1, number of controlled cores.
- RESET_CYCLES, 2, cycles core_reset_n is held low after start (must be >=1).
- TIMEOUT_CYCLES, 1000, run cycles before TIMEOUT (must be >=1).
- CNT_W, 32, cycle_count width.
- PC_W, 32, core PC width.
- STALL_CYCLES, 16, unchanged-PC cycles treated as halt (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begins or restarts a run.
- abort  in  1  one-cycle pulse; stops the run.
- core_halt  in  NUM_CORES  per-core halt indication, level.
- core_pc  in  NUM_CORES*PC_W  packed per-core PC; core i at bits [i*PC_W +: PC_W].
- core_reset_n  out  NUM_CORES  active-low reset to each core.
- busy  out  1  high in HOLD or RUN.
- done  out  1  high in DONE.
- timed_out  out  1  high in TIMEOUT.
- halted_mask  out  NUM_CORES  sticky per-core halted flags.
- cycle_count  out  CNT_W  run cycles elapsed.

Behaviour:
- All outputs are registered.
- Reset state (reset=1 at a clk edge):
  - state IDLE; core_reset_n all 0; busy/done/timed_out 0; halted_mask 0; cycle_count 0.
  - Reset overrides every other input in any state.
- States: IDLE, HOLD, RUN, DONE, TIMEOUT.
- IDLE:
  - cores held in reset;
  - start -> HOLD, clearing halted_mask, cycle_count and the hold counter.
- HOLD:
  - core_reset_n all 0;
  - hold counter counts RESET_CYCLES cycles, then -> RUN;
  - core_halt is ignored.
- Start timing: start sampled at edge T -> core_reset_n low for edges T+1..T+RESET_CYCLES, high from edge T+RESET_CYCLES+1.
- RUN:
  - core_reset_n all 1;
  - cycle_count increments every RUN cycle; first RUN cycle shows 1; saturates at all-ones;
  - halted_mask[i] sets on core_halt[i]=1 and stays set until the next start or reset.
  - When halted_mask (including bits setting this cycle) is all ones -> DONE.
  - Else when cycle_count reaches TIMEOUT_CYCLES -> TIMEOUT.
  - If all cores halt in the same cycle the timeout would fire, DONE wins.
- DONE / TIMEOUT:
  - cores held in reset (core_reset_n all 0);
  - cycle_count and halted_mask frozen;
  - start -> HOLD (restart).
- abort: in HOLD or RUN -> IDLE with core_reset_n 0; counters frozen; ignored in other states.
- start and abort asserted together: abort wins.
- start while busy is ignored.

Optional Feature:
- Macro: CPU_RUN_STALL_DETECT_EN.
- Defined: per-core stall counter in RUN.
  - Reloads to 0 whenever core_pc changes.
  - Increments otherwise.
  - Reaching STALL_CYCLES sets halted_mask[i] exactly as core_halt[i] would.
  - Counter is cleared on entering HOLD.
- Undefined: core_pc is unused and no stall logic is generated; halt comes only from core_halt.

Decomposition:
- Package cpu_run_pkg:
  - run_state_t enum (IDLE, HOLD, RUN, DONE, TIMEOUT);
  - default parameter constants.
- One sub-module, cpu_stall_detector: a single-core PC-compare plus counter, instantiated NUM_CORES times under the macro.

Test Plan:
- Reset, then start with RESET_CYCLES=2 -> core_reset_n low for 2 cycles, then high; busy=1; cycle_count=1 on first RUN cycle.
- NUM_CORES=2; core_halt[0] at run cycle 10, core_halt[1] at cycle 25:
  - halted_mask=01 after cycle 10;
  - DONE after cycle 25, done=1;
  - cycle_count frozen at 25; cores back in reset.
- TIMEOUT_CYCLES=50, no halts -> timed_out=1 after cycle_count reaches 50; then start -> HOLD with counters cleared.
- Last core halts on cycle 50 with TIMEOUT_CYCLES=50 -> DONE, timed_out=0.
- abort at run cycle 7 -> IDLE next cycle, core_reset_n=0, busy=0; start and abort in the same cycle from IDLE -> stays IDLE.
- With CPU_RUN_STALL_DETECT_EN, STALL_CYCLES=16: core_pc held at 0x40 with no core_halt -> halted_mask bit sets after 16 cycles; PC changing every cycle -> never sets.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared types and default parameter values
// for the core run sequencer (cpu_run_controller).
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    DONE,
    TIMEOUT
  } run_state_t;

  localparam int unsigned DEF_NUM_CORES      = 1;
  localparam int unsigned DEF_RESET_CYCLES   = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W          = 32;
  localparam int unsigned DEF_PC_W           = 32;
  localparam int unsigned DEF_STALL_CYCLES   = 16;

endpackage

// File: rtl/cpu_stall_detector.sv
// cpu_stall_detector: flags a core whose PC stays unchanged.
// Ports: clk, reset (sync, active-high), clear_i (zero the
// counter), en_i (count while running), pc_i (core PC),
// stall_o (counter reaches STALL_CYCLES this cycle).
module cpu_stall_detector
  import cpu_run_pkg::*;
#(
  parameter int unsigned PC_W         = DEF_PC_W,
  parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            stall_o
);

  localparam int unsigned SW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] LIM = SW'(STALL_CYCLES);

  logic [PC_W-1:0] pc_q;
  logic [SW-1:0]   cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (pc_i != pc_q)
        cnt_d = '0;
      else if (cnt_q != LIM)
        cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the cycle the count first reaches the limit
  // and stays high while the PC remains stuck.
  assign stall_o = en_i && (cnt_d == LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      // PC is tracked outside RUN too, so the first RUN
      // cycle compares against the PC held during reset.
      pc_q  <= pc_i;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: holds cores in reset, releases them,
// counts run cycles and ends the run as DONE or TIMEOUT.
// Ports: clk, reset (sync, active-high), start, abort,
// core_halt[N], core_pc[N*PC_W] -> core_reset_n[N], busy,
// done, timed_out, halted_mask[N], cycle_count[CNT_W].
// Optional PC-stall halt: define CPU_RUN_STALL_DETECT_EN.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int unsigned NUM_CORES      = DEF_NUM_CORES,
  parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned PC_W           = DEF_PC_W,
  parameter int unsigned STALL_CYCLES   = DEF_STALL_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_CORES-1:0]      core_halt,
  input  logic [NUM_CORES*PC_W-1:0] core_pc,
  output logic [NUM_CORES-1:0]      core_reset_n,
  output logic                      busy,
  output logic                      done,
  output logic                      timed_out,
  output logic [NUM_CORES-1:0]      halted_mask,
  output logic [CNT_W-1:0]          cycle_count
);

  localparam int unsigned HW = $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_END = HW'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  run_state_t           state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_CORES-1:0] stall_hit;
  logic [NUM_CORES-1:0] halt_now;

  logic [NUM_CORES-1:0] rstn_q;
  logic                 busy_q, done_q, to_q;

  assign halt_now = core_halt | stall_hit;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE, DONE, TIMEOUT: begin
        if (start && !abort) begin
          state_d = HOLD;
          hold_d  = '0;
          cnt_d   = '0;
          mask_d  = '0;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_END) begin
          state_d = RUN;
          cnt_d   = CNT_W'(1);
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          mask_d = mask_q | halt_now;
          // All-halted is tested first so it beats timeout.
          if (&mask_d)
            state_d = DONE;
          else if (cnt_q >= TO_LIM)
            state_d = TIMEOUT;
          else if (cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      rstn_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rstn_q  <= (state_d == RUN) ? '1 : '0;
      busy_q  <= (state_d == HOLD) || (state_d == RUN);
      done_q  <= (state_d == DONE);
      to_q    <= (state_d == TIMEOUT);
    end
  end

`ifdef CPU_RUN_STALL_DETECT_EN
  logic run_en;
  logic clr_stall;

  assign run_en    = (state_q == RUN);
  assign clr_stall = (state_d == HOLD) && (state_q != HOLD);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_stall
    cpu_stall_detector #(
      .PC_W         (PC_W),
      .STALL_CYCLES (STALL_CYCLES)
    ) u_det (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clr_stall),
      .en_i    (run_en),
      .pc_i    (core_pc[i*PC_W +: PC_W]),
      .stall_o (stall_hit[i])
    );
  end
`else
  logic unused_pc;
  assign unused_pc = ^core_pc;
  assign stall_hit = '0;
`endif

  assign core_reset_n = rstn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timed_out    = to_q;
  assign halted_mask  = mask_q;
  assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: vector table, directed run
// sequences and randomized checks against a run model.
module tb_cpu_run_controller;

  localparam int NC = 2;
  localparam int RC = 2;
  localparam int TO = 50;
  localparam int CW = 16;
  localparam int PW = 32;
  localparam int SC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [NC-1:0]    core_halt = '0;
  logic [NC*PW-1:0] core_pc = '0;
  logic [NC-1:0]    core_reset_n;
  logic             busy, done, timed_out;
  logic [NC-1:0]    halted_mask;
  logic [CW-1:0]    cycle_count;

  cpu_run_controller #(
    .NUM_CORES      (NC),
    .RESET_CYCLES   (RC),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW),
    .PC_W           (PW),
    .STALL_CYCLES   (SC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .core_halt    (core_halt),
    .core_pc      (core_pc),
    .core_reset_n (core_reset_n),
    .busy         (busy),
    .done         (done),
    .timed_out    (timed_out),
    .halted_mask  (halted_mask),
    .cycle_count  (cycle_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Run model: phase 0 off, 1 reset-hold, 2 running,
  // 3 finished, 4 expired.
  int            m_ph = 0;
  int            m_left = 0;
  int            m_cnt = 0;
  logic [NC-1:0] m_mask = '0;

  task automatic model_step(input logic r, input logic s,
                            input logic a,
                            input logic [NC-1:0] h);
    if (r) begin
      m_ph = 0; m_cnt = 0; m_mask = '0;
    end else if (m_ph == 1) begin
      if (a) m_ph = 0;
      else if (m_left == 0) begin m_ph = 2; m_cnt = 1; end
      else m_left--;
    end else if (m_ph == 2) begin
      if (a) m_ph = 0;
      else begin
        m_mask |= h;
        if (m_mask == {NC{1'b1}}) m_ph = 3;
        else if (m_cnt >= TO) m_ph = 4;
        else m_cnt++;
      end
    end else if (s && !a) begin
      m_ph = 1; m_left = RC; m_cnt = 0; m_mask = '0;
    end
  endtask

  logic [31:0] pc_step = 32'd0;
  logic        pc_freeze0 = 1'b0;

  task automatic cyc(input logic r, input logic s,
                     input logic a, input logic [NC-1:0] h);
    reset = r; start = s; abort = a; core_halt = h;
    core_pc[0 +: PW]  = pc_freeze0 ? 32'h40 : pc_step;
    core_pc[PW +: PW] = pc_step * 3 + 7;
    model_step(r, s, a, h);
    @(posedge clk);
    #1;
    pc_step++;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rstn"}, core_reset_n,
        (m_ph == 2) ? {NC{1'b1}} : '0);
    chk({tag, ".busy"}, busy, (m_ph == 1 || m_ph == 2));
    chk({tag, ".done"}, done, (m_ph == 3));
    chk({tag, ".to"}, timed_out, (m_ph == 4));
    chk({tag, ".mask"}, halted_mask, m_mask);
    chk({tag, ".cnt"}, cycle_count, m_cnt);
  endtask

  typedef struct {
    logic          r, s, a;
    logic [NC-1:0] h;
    logic [NC-1:0] rstn;
    logic          bsy, dn, to;
    logic [NC-1:0] mask;
    int            cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int first;
    tbl[0]  = '{1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0};
    tbl[1]  = '{0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0};
    tbl[2]  = '{0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 2'b00, 0};
    tbl[3]  = '{0, 0, 0, 2'b11, 2'b00, 1, 0, 0, 2'b00, 0};
    tbl[4]  = '{0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 2'b00, 0};
    tbl[5]  = '{0, 0, 0, 2'b00, 2'b11, 1, 0, 0, 2'b00, 1};
    tbl[6]  = '{0, 0, 0, 2'b01, 2'b11, 1, 0, 0, 2'b01, 2};
    tbl[7]  = '{0, 1, 0, 2'b00, 2'b11, 1, 0, 0, 2'b01, 3};
    tbl[8]  = '{0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b01, 3};
    tbl[9]  = '{0, 1, 1, 2'b00, 2'b00, 0, 0, 0, 2'b01, 3};
    tbl[10] = '{1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0};

    for (int i = 0; i < 11; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cyc(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].h);
      chk({t, ".rstn"}, core_reset_n, tbl[i].rstn);
      chk({t, ".busy"}, busy, tbl[i].bsy);
      chk({t, ".done"}, done, tbl[i].dn);
      chk({t, ".to"}, timed_out, tbl[i].to);
      chk({t, ".mask"}, halted_mask, tbl[i].mask);
      chk({t, ".cnt"}, cycle_count, tbl[i].cnt);
    end

    // Core 0 halts at run cycle 10, core 1 at 25.
    cyc(0, 1, 0, 2'b00);
    repeat (RC + 1) cyc(0, 0, 0, 2'b00);
    chk("halt.first_cnt", cycle_count, 1);
    chk("halt.rstn_hi", core_reset_n, 2'b11);
    for (int n = 1; n <= 25; n++) begin
      cyc(0, 0, 0, {n >= 25, n >= 10});
      if (n == 10) begin
        chk("halt.mask01", halted_mask, 2'b01);
        chk("halt.busy10", busy, 1);
      end
    end
    chk("halt.done", done, 1);
    chk("halt.cnt25", cycle_count, 25);
    chk("halt.rstn_lo", core_reset_n, 2'b00);
    chk("halt.busy0", busy, 0);
    cyc(0, 0, 0, 2'b00);
    chk("halt.frozen", cycle_count, 25);
    chk("halt.mask11", halted_mask, 2'b11);

    // No halts: timeout at 50, then restart.
    cyc(0, 1, 0, 2'b00);
    repeat (RC + 1) cyc(0, 0, 0, 2'b00);
    repeat (TO - 1) cyc(0, 0, 0, 2'b00);
    chk("to.cnt50", cycle_count, TO);
    chk("to.not_yet", timed_out, 0);
    cyc(0, 0, 0, 2'b00);
    chk("to.fired", timed_out, 1);
    chk("to.cnt_frz", cycle_count, TO);
    chk("to.rstn_lo", core_reset_n, 2'b00);
    cyc(0, 1, 0, 2'b00);
    chk("to.restart_busy", busy, 1);
    chk("to.restart_cnt", cycle_count, 0);
    chk("to.restart_to", timed_out, 0);

    // Last halt lands on the timeout cycle: DONE wins.
    repeat (RC + 1) cyc(0, 0, 0, 2'b00);
    for (int n = 1; n <= TO; n++)
      cyc(0, 0, 0, (n == TO) ? 2'b11 : 2'b00);
    chk("tie.done", done, 1);
    chk("tie.to", timed_out, 0);
    chk("tie.cnt", cycle_count, TO);

    // Abort at run cycle 7.
    cyc(0, 1, 0, 2'b00);
    repeat (RC + 1) cyc(0, 0, 0, 2'b00);
    repeat (6) cyc(0, 0, 0, 2'b00);
    chk("abort.cnt7", cycle_count, 7);
    cyc(0, 0, 1, 2'b00);
    chk("abort.busy", busy, 0);
    chk("abort.rstn", core_reset_n, 2'b00);
    chk("abort.cnt_frz", cycle_count, 7);
    cyc(0, 1, 1, 2'b00);
    chk("abort.both_idle", busy, 0);
    cyc(0, 0, 0, 2'b00);
    chk("abort.still_idle", busy, 0);

`ifdef CPU_RUN_STALL_DETECT_EN
    // Core 0 PC stuck at 0x40, core 1 PC moving.
    cyc(1, 0, 0, 2'b00);
    pc_freeze0 = 1'b1;
    cyc(0, 1, 0, 2'b00);
    repeat (RC + 1) cyc(0, 0, 0, 2'b00);
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(0, 0, 0, 2'b00);
      if (halted_mask[0] && first == 0) first = k;
    end
    chk("stall.after", first, SC);
    chk("stall.moving", halted_mask[1], 0);
    pc_freeze0 = 1'b0;
`else
    first = 0;
`endif

    // Randomized run against the model.
    cyc(1, 0, 0, 2'b00);
    chk_model("rst");
    for (int i = 0; i < 3000; i++) begin
      logic          r, s, a;
      logic [NC-1:0] h;
      r = ($urandom_range(0, 127) == 0);
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 31) == 0);
      for (int c = 0; c < NC; c++)
        h[c] = ($urandom_range(0, 23) == 0);
      cyc(r, s, a, h);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
